// File: rtl/cpu_fpu_int_to_float_if.sv
// cpu_fpu_int_to_float_if: request/ready handshake bundle between the FPU issue logic and the int-to-float converter
interface cpu_fpu_int_to_float_if #(parameter int INT_WIDTH = 32);
  logic                 request;
  logic [INT_WIDTH-1:0] op1;
  logic                 is_signed;
  logic [2:0]           rm;
  logic                 ready;
  logic [31:0]          result;
  logic                 inexact;
  modport master (output request, op1, is_signed, rm, input ready, result, inexact);
  modport slave (input request, op1, is_signed, rm, output ready, result, inexact);
endinterface

// File: rtl/cpu_fpu_int_to_float.sv
// cpu_fpu_int_to_float: multi-cycle FCVT.S.W/WU/L/LU with a shift-per-cycle normaliser, five rounding modes and NX
module cpu_fpu_int_to_float #(
  parameter int INT_WIDTH       = 32,
  parameter int SHIFT_PER_CYCLE = 1
) (
  input logic                   i_clock,
  input logic                   i_reset,
  cpu_fpu_int_to_float_if.slave bus
);
  localparam int W = INT_WIDTH;
  localparam int S = SHIFT_PER_CYCLE;
  typedef enum logic [2:0] {IDLE, NORM, ROUND, PACK, DONE} state_t;
  state_t state, state_n;
  logic         sgn, sgn_n, zero, zero_n, nx, nx_n, ready_n, res_nx_n, g, st, up;
  logic [2:0]   rm, rm_n;
  logic [7:0]   exp, exp_n;
  logic [W-1:0] mant, mant_n, mag;
  logic [22:0]  frac, frac_n;
  logic [31:0]  z, z_n, result_n;
  logic [23:0]  m24, m24_up;
  logic [3:0]   k;
  // leading zeros inside the top S bits of the mantissa; S means the whole window is empty
  always_comb begin
    k = 4'(S);
    for (int i = S - 1; i >= 0; i--) if (mant[W-1-i]) k = 4'(i);
  end
  assign mag    = (bus.is_signed && bus.op1[W-1]) ? -bus.op1 : bus.op1;
  assign m24    = mant[W-1 -: 24];
  assign g      = mant[W-25];
  assign st     = |mant[W-26:0];
  assign m24_up = m24 + {23'b0, up};
  assign up     = rm == 3'd1 ? 1'b0 :
                  rm == 3'd2 ? sgn & (g | st) :
                  rm == 3'd3 ? !sgn & (g | st) :
                  rm == 3'd4 ? g : g & (st | m24[0]);
  always_comb begin
    state_n  = state;
    sgn_n    = sgn;
    zero_n   = zero;
    nx_n     = nx;
    rm_n     = rm;
    exp_n    = exp;
    mant_n   = mant;
    frac_n   = frac;
    z_n      = z;
    ready_n  = bus.ready;
    result_n = bus.result;
    res_nx_n = bus.inexact;
    case (state)
      IDLE: if (bus.request) begin
        rm_n    = bus.rm;
        sgn_n   = bus.is_signed & bus.op1[W-1];
        zero_n  = bus.op1 == '0;
        nx_n    = 1'b0;
        exp_n   = 8'(W - 1);
        mant_n  = mag;
        frac_n  = '0;
        state_n = zero_n ? PACK : NORM;
      end
      NORM: if (k == 4'd0) state_n = ROUND;
        else begin
          mant_n = mant << k;
          exp_n  = exp - {4'b0, k};
        end
      ROUND: begin
        nx_n    = g | st;
        frac_n  = m24_up[22:0];
        exp_n   = exp + {7'b0, up & (&m24)};
        state_n = PACK;
      end
      PACK: begin
        z_n     = zero ? 32'h0 : {sgn, exp + 8'd127, frac};
        state_n = DONE;
      end
      DONE: begin
        result_n = z;
        res_nx_n = nx;
        ready_n  = bus.request;
        state_n  = bus.request ? DONE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) state <= i_reset ? IDLE : state_n;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sgn         <= 1'b0;
      zero        <= 1'b0;
      nx          <= 1'b0;
      rm          <= '0;
      exp         <= '0;
      mant        <= '0;
      frac        <= '0;
      z           <= '0;
      bus.ready   <= 1'b0;
      bus.result  <= '0;
      bus.inexact <= 1'b0;
    end else begin
      sgn         <= sgn_n;
      zero        <= zero_n;
      nx          <= nx_n;
      rm          <= rm_n;
      exp         <= exp_n;
      mant        <= mant_n;
      frac        <= frac_n;
      z           <= z_n;
      bus.ready   <= ready_n;
      bus.result  <= result_n;
      bus.inexact <= res_nx_n;
    end
  end
endmodule

// File: tb/tb_cpu_fpu_int_to_float.sv
// tb_cpu_fpu_int_to_float: directed and random conversions on a 32-bit/S=1 and a 64-bit/S=4 instance against an arithmetic model
module tb_cpu_fpu_int_to_float;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cpu_fpu_int_to_float_if #(.INT_WIDTH(32)) b32 ();
  cpu_fpu_int_to_float_if #(.INT_WIDTH(64)) b64 ();
  cpu_fpu_int_to_float #(.INT_WIDTH(32), .SHIFT_PER_CYCLE(1)) dut32 (.i_clock(clk), .i_reset(rst), .bus(b32.slave));
  cpu_fpu_int_to_float #(.INT_WIDTH(64), .SHIFT_PER_CYCLE(4)) dut64 (.i_clock(clk), .i_reset(rst), .bus(b64.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // model: exact integer value rounded to a 24-bit significand by comparing the remainder to half an ulp
  function automatic void model(input logic [63:0] op, input int w, input bit sgn_in, input logic [2:0] rm,
                                output logic [31:0] z, output bit nx, output int lat);
    logic [63:0] mask, mag, q, rem, half;
    bit s, up;
    int p, sh, e;
    mask = (w == 64) ? '1 : 64'hFFFF_FFFF;
    s    = sgn_in && op[w-1];
    mag  = (s ? 64'd0 - op : op) & mask;
    nx   = 1'b0;
    if (mag == 0) begin
      z   = 32'h0;
      lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    lat = ((w - 1 - p) + (w == 64 ? 3 : 0)) / (w == 64 ? 4 : 1) + 4;
    e   = p;
    if (p <= 23) q = mag << (23 - p);
    else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      nx   = rem != 0;
      case (rm)
        3'd1: up = 1'b0;
        3'd2: up = s && nx;
        3'd3: up = !s && nx;
        3'd4: up = rem >= half;
        default: up = (rem > half) || (rem == half && q[0]);
      endcase
      q = q + 64'(up);
      if (q == 64'h100_0000) begin
        q = 64'h80_0000;
        e++;
      end
    end
    z = {s, 8'(e + 127), q[22:0]};
  endfunction

  task automatic run(input bit big, input logic [63:0] op, input bit sgn, input logic [2:0] rm, input string tag);
    logic [31:0] ez;
    bit enx, rdy;
    int elat, e;
    model(op, big ? 64 : 32, sgn, rm, ez, enx, elat);
    @(negedge clk);
    if (big) begin
      b64.op1 = op; b64.is_signed = sgn; b64.rm = rm; b64.request = 1'b1;
    end else begin
      b32.op1 = op[31:0]; b32.is_signed = sgn; b32.rm = rm; b32.request = 1'b1;
    end
    e = -1;
    rdy = 1'b0;
    while (e < 200 && !rdy) begin
      @(posedge clk);
      e++;
      @(negedge clk);
      rdy = big ? b64.ready : b32.ready;
    end
    chk({tag, " ready"}, 64'(rdy), 64'd1);
    chk({tag, " latency"}, 64'(e), 64'(elat));
    chk({tag, " result"}, 64'(big ? b64.result : b32.result), 64'(ez));
    chk({tag, " inexact"}, 64'(big ? b64.inexact : b32.inexact), 64'(enx));
    b32.request = 1'b0;
    b64.request = 1'b0;
    @(negedge clk);
    chk({tag, " ready drop"}, 64'(big ? b64.ready : b32.ready), 64'd0);
    chk({tag, " result hold"}, 64'(big ? b64.result : b32.result), 64'(ez));
  endtask

  initial begin
    logic [63:0] r;
    b32.request = 1'b0; b32.op1 = '0; b32.is_signed = 1'b0; b32.rm = '0;
    b64.request = 1'b0; b64.op1 = '0; b64.is_signed = 1'b0; b64.rm = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset ready32", 64'(b32.ready), 64'd0);
    chk("reset result32", 64'(b32.result), 64'd0);
    chk("reset nx32", 64'(b32.inexact), 64'd0);
    chk("reset ready64", 64'(b64.ready), 64'd0);
    chk("reset result64", 64'(b64.result), 64'd0);
    run(0, 64'd1, 1, 3'd0, "one32");
    run(0, 64'd0, 1, 3'd0, "zero32");
    run(0, 64'hFFFF_FFFF, 1, 3'd0, "m1 signed");
    run(0, 64'hFFFF_FFFF, 0, 3'd0, "max unsigned rne");
    run(0, 64'hFFFF_FFFF, 0, 3'd1, "max unsigned rtz");
    run(0, 64'h8000_0000, 1, 3'd0, "most negative");
    for (int m = 0; m < 8; m++) run(0, 64'h0100_0001, 0, 3'(m), "tie rm");
    run(0, 64'hFEFF_FFFF, 1, 3'd2, "neg rdn");
    run(0, 64'h00FF_FFFF, 0, 3'd3, "24 bit exact");
    run(1, 64'd1, 0, 3'd0, "one64");
    run(1, '1, 0, 3'd0, "max64 unsigned");
    run(1, 64'h8000_0000_0000_0000, 1, 3'd4, "most negative64");
    run(1, 64'd0, 0, 3'd3, "zero64");
    for (int n = 0; n < 20; n++) begin
      r = {$urandom, $urandom} >> $urandom_range(0, 63);
      run(1, r, 1'($urandom), 3'($urandom_range(0, 7)), "rand64");
      r = 64'($urandom >> $urandom_range(0, 31));
      run(0, r, 1'($urandom), 3'($urandom_range(0, 7)), "rand32");
    end
    @(negedge clk);
    b32.op1 = 32'd1; b32.is_signed = 1'b0; b32.rm = 3'd0; b32.request = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b32.request = 1'b0;
    chk("midreset ready", 64'(b32.ready), 64'd0);
    chk("midreset result", 64'(b32.result), 64'd0);
    chk("midreset nx", 64'(b32.inexact), 64'd0);
    run(0, 64'd3, 0, 3'd0, "after reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
